// File: rtl/fpnew_issue_pkg.sv
// fpnew_issue_pkg
//   Shared types for the FPU issue controller: local copies of the fpnew
//   operation, rounding-mode, format and status encodings. These keep the
//   slice self-contained and carry the same bit encodings as the fpnew enums.
//   The package also defines the reorder-slot entry, the tag-width helper and
//   the performance-counter width.
//   Optional feature macro used by the controller: FPNEW_ISSUE_PERF_EN.
package fpnew_issue_pkg;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    DYN = 3'b111
  } roundmode_e;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  // Slot storage is sized for the widest supported datapath. Narrower
  // builds zero-extend on write, so the unused upper bits hold constants.
  localparam int MAX_WIDTH = 64;

  typedef struct packed {
    logic [MAX_WIDTH-1:0] result;
    status_t              status;
  } rob_entry_t;

  localparam int PERF_W = 32;

  function automatic int tag_width(input int num_tags);
    return (num_tags > 1) ? $clog2(num_tags) : 1;
  endfunction

endpackage

// File: rtl/fpnew_issue_rob.sv
// fpnew_issue_rob
//   Reorder buffer for the FPU issue controller. Slots are allocated in
//   order at issue (tail). Results may be written back out of order by tag.
//   Slots retire in order from head once their result is present.
//   Ports:
//     clk, rst      clock, synchronous active-high reset (also clears err)
//     flush         drops all in-flight slots; err is kept
//     issue         allocate slot at tail
//     retire        free slot at head (caller guarantees head_done)
//     res_valid/res_tag/res_entry  tagged result write-back
//     tail          tag for the next issue
//     count         allocated slots
//     full          count == NUM_TAGS
//     head_done/head_entry  in-order output slot
//     err           sticky: result for a slot not awaiting one
module fpnew_issue_rob
  import fpnew_issue_pkg::*;
#(
  parameter int NUM_TAGS = 4,
  parameter int TAG_W    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             issue,
  input  logic             retire,
  input  logic             res_valid,
  input  logic [TAG_W-1:0] res_tag,
  input  rob_entry_t       res_entry,
  output logic [TAG_W-1:0] tail,
  output logic [TAG_W:0]   count,
  output logic             full,
  output logic             head_done,
  output rob_entry_t       head_entry,
  output logic             err
);

  localparam int CNT_W = TAG_W + 1;

  logic [NUM_TAGS-1:0] alloc;
  logic [NUM_TAGS-1:0] done;
  logic [TAG_W-1:0]    head;
  rob_entry_t          slots [NUM_TAGS];
  logic                res_ok;
  logic                capture;

  // A result is accepted only for a slot that was issued and is still waiting.
  // Results that arrive while a flush or reset is active are dropped silently.
  assign res_ok  = alloc[res_tag] & ~done[res_tag];
  assign capture = res_valid & res_ok & ~rst & ~flush;

  assign full       = (count == CNT_W'(NUM_TAGS));
  assign head_done  = done[head];
  assign head_entry = slots[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc <= '0;
      done  <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      err   <= 1'b0;
    end else if (flush) begin
      alloc <= '0;
      done  <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      // The tail slot is always free when issue is allowed, and the head slot
      // is never the tail while it retires. The two updates therefore never
      // touch the same index.
      if (issue) begin
        alloc[tail] <= 1'b1;
        done[tail]  <= 1'b0;
        tail        <= tail + TAG_W'(1);
      end
      if (retire) begin
        alloc[head] <= 1'b0;
        done[head]  <= 1'b0;
        head        <= head + TAG_W'(1);
      end
      if (capture) begin
        done[res_tag] <= 1'b1;
      end
      if (res_valid && !res_ok) begin
        err <= 1'b1;
      end
      count <= count + CNT_W'(issue) - CNT_W'(retire);
    end
  end

  // Payload storage needs no reset; done[] gates every read of it.
  always_ff @(posedge clk) begin
    if (capture) begin
      slots[res_tag] <= res_entry;
    end
  end

endmodule

// File: rtl/fpnew_issue_ctrl.sv
// fpnew_issue_ctrl
//   Initiator side of the fpnew_top handshake. The block tags core FP
//   requests and issues them. Tagged results may return out of order and are
//   handed back to the core in issue order.
//   Ports:
//     clk_i, rst_i                      clock, synchronous active-high reset
//     req_*                             core request (valid/ready, operands, op fields)
//     rsp_*                             in-order result to the core (valid/ready, result, status)
//     fpu_valid_o/fpu_ready_i/fpu_tag_o issue handshake to fpnew_top
//     fpu_operands_o, fpu_op_o ...      request fields passed straight through
//     fpu_result_*                      result handshake from fpnew_top (never back-pressured)
//     flush_i/fpu_flush_o               abort everything in flight
//     busy_o                            any slot allocated or a result arriving
//     err_o                             sticky: result with an unallocated tag
//   Optional: define FPNEW_ISSUE_PERF_EN to add perf_issued_o / perf_stall_o.
module fpnew_issue_ctrl
  import fpnew_issue_pkg::*;
#(
  parameter  int WIDTH    = 16,
  parameter  int NUM_TAGS = 4,
  localparam int TAG_W    = tag_width(NUM_TAGS)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [3*WIDTH-1:0] req_operands_i,
  input  operation_e         req_op_i,
  input  roundmode_e         req_rnd_mode_i,
  input  logic               req_op_mod_i,
  input  fp_format_e         req_src_fmt_i,
  input  fp_format_e         req_dst_fmt_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [WIDTH-1:0]   rsp_result_o,
  output status_t            rsp_status_o,
  output logic               fpu_valid_o,
  input  logic               fpu_ready_i,
  output logic [TAG_W-1:0]   fpu_tag_o,
  output logic [3*WIDTH-1:0] fpu_operands_o,
  output operation_e         fpu_op_o,
  output roundmode_e         fpu_rnd_mode_o,
  output logic               fpu_op_mod_o,
  output fp_format_e         fpu_src_fmt_o,
  output fp_format_e         fpu_dst_fmt_o,
  input  logic               fpu_result_valid_i,
  output logic               fpu_result_ready_o,
  input  logic [WIDTH-1:0]   fpu_result_i,
  input  status_t            fpu_status_i,
  input  logic [TAG_W-1:0]   fpu_tag_i,
  input  logic               flush_i,
  output logic               fpu_flush_o,
  output logic               busy_o,
`ifdef FPNEW_ISSUE_PERF_EN
  output logic [PERF_W-1:0]  perf_issued_o,
  output logic [PERF_W-1:0]  perf_stall_o,
`endif
  output logic               err_o
);

  logic             issue;
  logic             retire;
  logic             full;
  logic             head_done;
  logic [TAG_W:0]   count;
  logic [TAG_W-1:0] tail;
  rob_entry_t       res_entry;
  rob_entry_t       head_entry;

  // fpu_valid_o is built only from core-side state so fpnew_top's
  // combinational ready cannot close a loop back through it.
  assign fpu_valid_o = req_valid_i & ~full & ~flush_i & ~rst_i;
  assign req_ready_o = fpu_valid_o & fpu_ready_i;
  assign issue       = req_ready_o;
  assign fpu_tag_o   = tail;

  assign fpu_operands_o = req_operands_i;
  assign fpu_op_o       = req_op_i;
  assign fpu_rnd_mode_o = req_rnd_mode_i;
  assign fpu_op_mod_o   = req_op_mod_i;
  assign fpu_src_fmt_o  = req_src_fmt_i;
  assign fpu_dst_fmt_o  = req_dst_fmt_i;

  // Every outstanding op already owns a slot, so results are always accepted.
  assign fpu_result_ready_o = 1'b1;
  assign fpu_flush_o        = flush_i;

  assign res_entry.result = MAX_WIDTH'(fpu_result_i);
  assign res_entry.status = fpu_status_i;

  assign rsp_valid_o  = head_done;
  assign rsp_result_o = head_entry.result[WIDTH-1:0];
  assign rsp_status_o = head_entry.status;
  assign retire       = rsp_valid_o & rsp_ready_i;

  assign busy_o = (count != '0) | fpu_result_valid_i;

  fpnew_issue_rob #(
    .NUM_TAGS (NUM_TAGS),
    .TAG_W    (TAG_W)
  ) u_rob (
    .clk        (clk_i),
    .rst        (rst_i),
    .flush      (flush_i),
    .issue      (issue),
    .retire     (retire),
    .res_valid  (fpu_result_valid_i),
    .res_tag    (fpu_tag_i),
    .res_entry  (res_entry),
    .tail       (tail),
    .count      (count),
    .full       (full),
    .head_done  (head_done),
    .head_entry (head_entry),
    .err        (err_o)
  );

`ifdef FPNEW_ISSUE_PERF_EN
  // Free-running event counters. They wrap naturally, and only reset clears them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_issued_o <= '0;
      perf_stall_o  <= '0;
    end else begin
      if (issue) begin
        perf_issued_o <= perf_issued_o + PERF_W'(1);
      end
      if (req_valid_i && !req_ready_o) begin
        perf_stall_o <= perf_stall_o + PERF_W'(1);
      end
    end
  end
`endif

endmodule
